hit_pair_pack: RTL

Two-lane hit packer between the single-sample test stage (R16) and the two-lane z-buffer stage (R18).
- Accepts at most one hit sample per cycle and buffers it in a small FIFO.
- Emits hits two at a time on the lane[1:0] bus that the z-buffer consumes.
- Pairs only samples of the same triangle. The z-buffer takes its colour from lane 0 only, so a lane-1 hit from a different triangle would be shaded wrong.
- Flushes single hits at triangle end or after an idle timeout.

---
 rtl/hit_pair_pack_if.sv | 39 +++
 rtl/hit_pair_pack.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hit_pair_pack_if.sv
`default_nettype none
// ============================================================================
// Module   : hit_pair_pack_if
// Purpose  : Bundle of the single-lane R16 hit input, the upstream hold
//            flag, the downstream stall flag and the two-lane R18 output
//            of the hit pair packer.
// Revision : 1.0 - initial release
// ============================================================================
interface hit_pair_pack_if #(
  parameter int SIGFIG = 24,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  // Upstream (R16) side: one hit per cycle
  logic signed [AXIS-1:0][SIGFIG-1:0]          hit_R16S;
  logic        [COLORS-1:0][SIGFIG-1:0]        color_R16U;
  logic                                        hit_valid_R16H;
  logic                                        tri_last_R16H;
  logic                                        halt_RnnnnL;

  // Downstream (R18) side: two lanes, lane 0 is the older hit
  logic                                        halt_R18L;
  logic signed [1:0][AXIS-1:0][SIGFIG-1:0]     hit_R18S;
  logic        [1:0][COLORS-1:0][SIGFIG-1:0]   color_R18U;
  logic        [1:0]                           hit_valid_R18H;

  // Environment view: drives hits and the downstream stall
  modport master (
    output hit_R16S, color_R16U, hit_valid_R16H, tri_last_R16H, halt_R18L,
    input  halt_RnnnnL, hit_R18S, color_R18U, hit_valid_R18H
  );

  // Packer view
  modport slave (
    input  hit_R16S, color_R16U, hit_valid_R16H, tri_last_R16H, halt_R18L,
    output halt_RnnnnL, hit_R18S, color_R18U, hit_valid_R18H
  );
endinterface : hit_pair_pack_if
`default_nettype wire

// File: rtl/hit_pair_pack.sv
`default_nettype none
// ============================================================================
// Module   : hit_pair_pack
// Purpose  : Buffers single-lane hit samples in a small FIFO and emits them
//            two at a time to the two-lane z-buffer stage. Only hits of the
//            same triangle are paired; a lone hit goes out single at the end
//            of its triangle or after an idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module hit_pair_pack #(
  parameter int SIGFIG   = 24,
  parameter int RADIX    = 10,
  parameter int AXIS     = 3,
  parameter int COLORS   = 3,
  parameter int DEPTH    = 8,
  parameter int WAIT_CYC = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,   // asynchronous, active-low
  hit_pair_pack_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants and types
  // --------------------------------------------------------------------------
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_TMO_W = (WAIT_CYC < 1) ? 1 : $clog2(WAIT_CYC + 1);

  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_TWO  = c_CNT_W'(2);
  localparam logic [c_TMO_W-1:0] c_WAIT = c_TMO_W'(WAIT_CYC);

  typedef logic signed [AXIS-1:0][SIGFIG-1:0] hit_t;
  typedef logic        [COLORS-1:0][SIGFIG-1:0] col_t;

  // IDLE: FIFO empty. WAIT: a lone non-last hit sits at the head and the
  // timeout counter is allowed to run. ACTIVE: anything else.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  // Elaboration-time sanity checks on the configuration
  generate
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("hit_pair_pack: DEPTH must be a power of two and at least 4");
    end
    if ((RADIX < 0) || (RADIX >= SIGFIG)) begin : g_bad_radix
      $error("hit_pair_pack: RADIX must lie in [0, SIGFIG)");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  hit_t               r_hit_mem [DEPTH];
  col_t               r_col_mem [DEPTH];
  logic [DEPTH-1:0]   r_last_mem;

  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_TMO_W-1:0] r_tmo;
  state_t             r_state;

  logic signed [1:0][AXIS-1:0][SIGFIG-1:0]   r_hit_o;
  logic        [1:0][COLORS-1:0][SIGFIG-1:0] r_col_o;
  logic        [1:0]                         r_valid_o;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic               w_not_full;
  logic               w_push;
  logic               w_run;
  logic               w_head_last;
  logic [c_PTR_W-1:0] w_rd_p1;
  logic               w_pair;
  logic               w_single;
  logic [1:0]         w_pop_n;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [c_CNT_W-1:0] w_left;
  logic [c_PTR_W-1:0] w_rd_nxt;
  logic               w_nxt_head_last;
  state_t             w_state_nxt;

  assign w_not_full  = (r_count < c_FULL);
  assign w_push      = bus.hit_valid_R16H & w_not_full;
  assign w_run       = bus.halt_R18L;
  assign w_head_last = r_last_mem[r_rd_ptr];
  assign w_rd_p1     = r_rd_ptr + c_PTR_W'(1);

  // Pop decision, made against the FIFO contents before this cycle's push
  always_comb begin
    w_pair   = 1'b0;
    w_single = 1'b0;
    if (w_run) begin
      if ((r_count >= c_TWO) && !w_head_last) begin
        w_pair = 1'b1;
      end else if ((r_count != '0) && w_head_last) begin
        w_single = 1'b1;
      end else if ((r_state == S_WAIT) && (r_tmo == c_WAIT)) begin
        w_single = 1'b1;
      end
    end
  end

  assign w_pop_n   = w_pair ? 2'd2 : (w_single ? 2'd1 : 2'd0);
  assign w_cnt_nxt = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop_n);
  assign w_left    = r_count - c_CNT_W'(w_pop_n);
  assign w_rd_nxt  = r_rd_ptr + c_PTR_W'(w_pop_n);

  // Next state: classify the FIFO as it will look after this edge. When no
  // old entry survives the pops, the new head is the hit being pushed now.
  always_comb begin
    w_nxt_head_last = r_last_mem[w_rd_nxt];
    if (w_left == '0) begin
      w_nxt_head_last = bus.tri_last_R16H;
    end
    w_state_nxt = S_ACTIVE;
    if (w_cnt_nxt == '0) begin
      w_state_nxt = S_IDLE;
    end else if ((w_cnt_nxt == c_ONE) && !w_nxt_head_last) begin
      w_state_nxt = S_WAIT;
    end
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FIFO payload write; contents need no reset because pointers gate reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_hit_mem[r_wr_ptr]  <= bus.hit_R16S;
      r_col_mem[r_wr_ptr]  <= bus.color_R16U;
      r_last_mem[r_wr_ptr] <= bus.tri_last_R16H;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_push);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
    end
  end

  // Idle timeout: counts while a lone non-last hit waits and nothing arrives,
  // clears on any pop or push, saturates, and freezes under downstream stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= '0;
    end else if (w_push || w_pair || w_single) begin
      r_tmo <= '0;
    end else if (w_run && (r_state == S_WAIT) && (r_tmo != c_WAIT)) begin
      r_tmo <= r_tmo + c_TMO_W'(1);
    end
  end

  // R18 output lanes: load on pop, drop valid on an idle run cycle, hold on stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_o   <= '0;
      r_col_o   <= '0;
      r_valid_o <= 2'b00;
    end else if (w_pair || w_single) begin
      r_hit_o[0] <= r_hit_mem[r_rd_ptr];
      r_col_o[0] <= r_col_mem[r_rd_ptr];
      if (w_pair) begin
        r_hit_o[1] <= r_hit_mem[w_rd_p1];
        r_col_o[1] <= r_col_mem[w_rd_p1];
        r_valid_o  <= 2'b11;
      end else begin
        r_hit_o[1] <= '0;
        r_col_o[1] <= '0;
        r_valid_o  <= 2'b01;
      end
    end else if (w_run) begin
      r_valid_o <= 2'b00;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.halt_RnnnnL    = w_not_full;
  assign bus.hit_R18S       = r_hit_o;
  assign bus.color_R18U     = r_col_o;
  assign bus.hit_valid_R18H = r_valid_o;

endmodule : hit_pair_pack
`default_nettype wire
